// File: rtl/axis_mem_sink.sv
// AXI-Stream frame capture sink: stores one frame (up to tlast) into a byte-lane
// strobed memory, reports length/completion/overflow, and offers registered readback.
module axis_mem_sink_lane #(
  parameter int DEPTH      = 4096,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  gclk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [7:0]            wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [7:0]            rdata_o
);
  logic [7:0] mem [DEPTH];
  logic [7:0] rdata_q;

  always_ff @(posedge gclk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  // Non-blocking read of the array gives read-before-write on address collision.
  always_ff @(posedge gclk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

module axis_mem_sink #(
  parameter int MEM_SIZE   = 4096,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    s03_axis_aclk,
  input  logic                    s03_axis_areset,
  input  logic                    s03_axis_enable,
  input  logic [DATA_WIDTH-1:0]   s03_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s03_axis_tstrb,
  input  logic                    s03_axis_tvalid,
  input  logic                    s03_axis_tlast,
  output logic                    s03_axis_tready,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic [ADDR_WIDTH:0]     frame_len,
  output logic                    frame_done,
  output logic                    overflow
);
  localparam int NUM_LANES = DATA_WIDTH / 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RECV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = 1;
  localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(MEM_SIZE - 1);
  localparam logic [ADDR_WIDTH:0]   LEN_FULL = (ADDR_WIDTH + 1)'(MEM_SIZE);
  localparam logic [ADDR_WIDTH:0]   LEN_ONE  = 1;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic                  tready_q;
  logic [ADDR_WIDTH:0]   frame_len_q, frame_len_d;
  logic                  done_q, done_d;
  logic                  ovf_q, ovf_d;
  logic                  accept;

  assign accept = s03_axis_tvalid & tready_q;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    frame_len_d = frame_len_q;
    done_d      = 1'b0;
    ovf_d       = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (s03_axis_enable) begin
          state_d  = S_RECV;
          wr_ptr_d = '0;
          ovf_d    = 1'b0;
        end
      end
      S_RECV: begin
        if (accept) begin
          // A completing beat wins over a same-cycle enable drop.
          if (s03_axis_tlast) begin
            frame_len_d = {1'b0, wr_ptr_q} + LEN_ONE;
            done_d      = 1'b1;
            state_d     = S_DONE;
          end else if (wr_ptr_q == PTR_LAST) begin
            frame_len_d = LEN_FULL;
            ovf_d       = 1'b1;
            done_d      = 1'b1;
            state_d     = S_DONE;
          end else begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (!s03_axis_enable) state_d = S_IDLE;
          end
        end else if (!s03_axis_enable) begin
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        if (!s03_axis_enable) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge s03_axis_aclk or posedge s03_axis_areset) begin
    if (s03_axis_areset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      tready_q    <= 1'b0;
      frame_len_q <= '0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      tready_q    <= (state_d == S_RECV);
      frame_len_q <= frame_len_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : gen_lane
    axis_mem_sink_lane #(
      .DEPTH      (MEM_SIZE),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_lane (
      .gclk    (s03_axis_aclk),
      .rst     (s03_axis_areset),
      .we_i    (accept & s03_axis_tstrb[i]),
      .waddr_i (wr_ptr_q),
      .wdata_i (s03_axis_tdata[8*i +: 8]),
      .raddr_i (rd_addr),
      .rdata_o (rd_data[8*i +: 8])
    );
  end

  assign s03_axis_tready = tready_q;
  assign frame_len       = frame_len_q;
  assign frame_done      = done_q;
  assign overflow        = ovf_q;
endmodule
